// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and helpers for the instruction fetch stage
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_MISS = 2'd2
    } fetch_state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_cnt.sv
// rtl/instr_fetch_cnt.sv - saturating performance counter, cleared only by reset
module instr_fetch_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, ICache read port, miss stall, registered word to decode
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      ic_rd_addr,
    output logic             ic_rd_req,
    input  logic             ic_rd_wait,
    input  logic [31:0]      ic_rd_data,
    input  logic             dec_stall,
    input  logic             jmp,
    input  logic [31:0]      jmp_pc,
    output logic [31:0]      insn,
    output logic [31:0]      insn_pc,
    output logic             insn_valid,
    output logic [CNT_W-1:0] miss_cycles
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  insn_q, insn_d;
    logic [31:0]  insn_pc_q, insn_pc_d;
    logic         insn_valid_q, insn_valid_d;
    logic         hold;
    logic         req;
    logic         hit;
    logic         miss;

    // Request depends only on registered state and dec_stall, never on jmp.
    assign hold = dec_stall && insn_valid_q;
    assign req  = !rst && (state_q != ST_IDLE) && !hold;
    assign hit  = req && !ic_rd_wait;
    assign miss = req && ic_rd_wait;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        insn_d       = insn_q;
        insn_pc_d    = insn_pc_q;
        insn_valid_d = insn_valid_q;
        if (jmp) begin
            // Flush: any same-cycle hit is discarded and decode sees a bubble.
            state_d      = ST_RUN;
            pc_d         = align_word(jmp_pc);
            insn_valid_d = 1'b0;
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
        end else if (hit) begin
            state_d      = ST_RUN;
            insn_d       = ic_rd_data;
            insn_pc_d    = pc_q;
            insn_valid_d = 1'b1;
            pc_d         = pc_q + WORD_BYTES;
        end else if (miss) begin
            state_d      = ST_MISS;
            insn_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= align_word(RESET_PC);
            insn_q       <= '0;
            insn_pc_q    <= '0;
            insn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            insn_q       <= insn_d;
            insn_pc_q    <= insn_pc_d;
            insn_valid_q <= insn_valid_d;
        end
    end

    instr_fetch_cnt #(
        .CNT_W(CNT_W)
    ) u_miss_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (state_q == ST_MISS),
        .count(miss_cycles)
    );

    assign ic_rd_addr = pc_q;
    assign ic_rd_req  = req;
    assign insn       = insn_q;
    assign insn_pc    = insn_pc_q;
    assign insn_valid = insn_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a behavioural reference model
module tb_instr_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters, checked against the model.
    logic        a_rst = 1'b1, a_wait = 1'b0, a_stall = 1'b0, a_jmp = 1'b0;
    logic [31:0] a_jmp_pc = '0;
    logic [31:0] a_addr, a_data, a_insn, a_insn_pc, a_miss;
    logic        a_req, a_valid;

    // Instance B: wrap-around reset PC and a narrow counter.
    logic        b_rst = 1'b1, b_wait = 1'b0, b_stall = 1'b0, b_jmp = 1'b0;
    logic [31:0] b_jmp_pc = '0;
    logic [31:0] b_addr, b_data, b_insn, b_insn_pc;
    logic [2:0]  b_miss;
    logic        b_req, b_valid;

    // Cache contents: every word is its own address xor a fixed pattern.
    assign a_data = a_addr ^ 32'hA5A5_0000;
    assign b_data = b_addr ^ 32'hA5A5_0000;

    instr_fetch u_a (
        .clk(clk), .rst(a_rst), .ic_rd_addr(a_addr), .ic_rd_req(a_req),
        .ic_rd_wait(a_wait), .ic_rd_data(a_data), .dec_stall(a_stall),
        .jmp(a_jmp), .jmp_pc(a_jmp_pc), .insn(a_insn), .insn_pc(a_insn_pc),
        .insn_valid(a_valid), .miss_cycles(a_miss)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) u_b (
        .clk(clk), .rst(b_rst), .ic_rd_addr(b_addr), .ic_rd_req(b_req),
        .ic_rd_wait(b_wait), .ic_rd_data(b_data), .dec_stall(b_stall),
        .jmp(b_jmp), .jmp_pc(b_jmp_pc), .insn(b_insn), .insn_pc(b_insn_pc),
        .insn_valid(b_valid), .miss_cycles(b_miss)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of instance A.
    logic [31:0] m_pc, m_insn, m_insn_pc, m_cnt;
    logic        m_valid, m_started, m_in_miss;

    task automatic model_step();
        if (a_rst) begin
            m_pc = 32'h0; m_insn = 32'h0; m_insn_pc = 32'h0; m_cnt = 32'h0;
            m_valid = 1'b0; m_started = 1'b0; m_in_miss = 1'b0;
        end else begin
            if (m_in_miss && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (a_jmp) begin
                m_pc = {a_jmp_pc[31:2], 2'b00};
                m_valid = 1'b0; m_in_miss = 1'b0; m_started = 1'b1;
            end else if (!m_started) begin
                m_started = 1'b1;
            end else if (a_stall && m_valid) begin
                // decode holding: nothing moves
            end else if (a_wait) begin
                m_valid = 1'b0; m_in_miss = 1'b1;
            end else begin
                m_insn = m_pc ^ 32'hA5A5_0000;
                m_insn_pc = m_pc;
                m_valid = 1'b1;
                m_pc = m_pc + 32'd4;
                m_in_miss = 1'b0;
            end
        end
    endtask

    function automatic logic model_req();
        return !a_rst && m_started && !(a_stall && m_valid);
    endfunction

    task automatic drive_a(input logic rst, input logic wt, input logic stall,
                           input logic jmp, input logic [31:0] jpc);
        @(negedge clk);
        a_rst = rst; a_wait = wt; a_stall = stall; a_jmp = jmp; a_jmp_pc = jpc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic reset_a();
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(); tick();
        n_cmp++;
        if ({a_req, a_valid, a_insn, a_insn_pc, a_addr, a_miss} !== 130'h0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%0b valid=%0b insn=%h insn_pc=%h addr=%h miss=%0d, required all 0",
                     a_req, a_valid, a_insn, a_insn_pc, a_addr, a_miss);
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (a_req !== 1'b0) begin
            n_err++; $display("FAIL reset_idle_req: got %0b, required 0", a_req);
        end
        tick();
        n_cmp++;
        if (a_req !== 1'b1 || a_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_first_req: req=%0b addr=%h, required 1/00000000", a_req, a_addr);
        end
    endtask

    task automatic test_stream();
        reset_a();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (a_valid !== 1'b1 || a_insn_pc !== 32'(i * 4) || a_insn !== (32'(i * 4) ^ 32'hA5A5_0000)) begin
                n_err++;
                $display("FAIL stream_%0d: valid=%0b insn_pc=%h insn=%h, required 1/%h/%h",
                         i, a_valid, a_insn_pc, a_insn, 32'(i * 4), 32'(i * 4) ^ 32'hA5A5_0000);
            end
        end
    endtask

    task automatic test_miss();
        reset_a();
        for (int i = 0; i < 16; i++) tick();
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (a_addr !== 32'h40 || a_valid !== 1'b0) begin
                n_err++; $display("FAIL miss_hold_%0d: addr=%h valid=%0b, required 00000040/0", i, a_addr, a_valid);
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        n_cmp++;
        if (a_miss !== 32'd5 || a_insn_pc !== 32'h40 || a_valid !== 1'b1) begin
            n_err++;
            $display("FAIL miss_recover: miss=%0d insn_pc=%h valid=%0b, required 5/00000040/1", a_miss, a_insn_pc, a_valid);
        end
    endtask

    task automatic test_stall();
        reset_a();
        tick(); tick(); tick();
        drive_a(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (a_insn_pc !== 32'h8 || a_valid !== 1'b1 || a_addr !== 32'hC || a_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold_%0d: insn_pc=%h valid=%0b addr=%h req=%0b, required 00000008/1/0000000c/0",
                         i, a_insn_pc, a_valid, a_addr, a_req);
            end
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        n_cmp++;
        if (a_insn_pc !== 32'hC || a_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_release: insn_pc=%h valid=%0b, required 0000000c/1", a_insn_pc, a_valid);
        end
    endtask

    task automatic test_redirect();
        reset_a();
        tick(); tick();
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive_a(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_1003);
        tick();
        n_cmp++;
        if (a_valid !== 1'b0 || a_addr !== 32'h1000 || a_miss !== 32'd1) begin
            n_err++;
            $display("FAIL redirect_flush: valid=%0b addr=%h miss=%0d, required 0/00001000/1", a_valid, a_addr, a_miss);
        end
        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        n_cmp++;
        if (a_req !== 1'b1) begin
            n_err++; $display("FAIL redirect_req: got %0b, required 1", a_req);
        end
        tick();
        n_cmp++;
        if (a_insn_pc !== 32'h1000 || a_valid !== 1'b1 || a_miss !== 32'd1) begin
            n_err++;
            $display("FAIL redirect_target: insn_pc=%h valid=%0b miss=%0d, required 00001000/1/1", a_insn_pc, a_valid, a_miss);
        end
    endtask

    task automatic test_random();
        logic        r_rst, r_wait, r_stall, r_jmp;
        logic [31:0] r_pc;
        int          bad = 0;
        reset_a();
        for (int i = 0; i < 2000; i++) begin
            r_rst   = ($urandom_range(0, 99) == 0);
            r_jmp   = ($urandom_range(0, 15) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_wait  = ($urandom_range(0, 2) == 0);
            r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            drive_a(r_rst, r_wait, r_stall, r_jmp, r_pc);
            #1;
            n_cmp++;
            if (a_req !== model_req() || a_addr !== m_pc) begin
                n_err++; bad++;
                if (bad < 10) $display("FAIL random_req_%0d: req=%0b addr=%h, required %0b/%h", i, a_req, a_addr, model_req(), m_pc);
            end
            tick();
            n_cmp++;
            if (a_valid !== m_valid || a_insn !== m_insn || a_insn_pc !== m_insn_pc || a_miss !== m_cnt) begin
                n_err++; bad++;
                if (bad < 10)
                    $display("FAIL random_out_%0d: valid=%0b insn=%h insn_pc=%h miss=%0d, required %0b/%h/%h/%0d",
                             i, a_valid, a_insn, a_insn_pc, a_miss, m_valid, m_insn, m_insn_pc, m_cnt);
            end
        end
    endtask

    task automatic test_wrap_saturate();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        drive_a(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        b_rst = 1'b1; b_wait = 1'b0;
        tick(); tick();
        @(negedge clk); b_rst = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (b_insn_pc !== exp_pc[i] || b_valid !== 1'b1) begin
                n_err++; $display("FAIL wrap_%0d: insn_pc=%h valid=%0b, required %h/1", i, b_insn_pc, b_valid, exp_pc[i]);
            end
        end
        @(negedge clk); b_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 6) begin
                n_cmp++;
                if (b_miss !== 3'd6) begin
                    n_err++; $display("FAIL sat_pre: miss=%0d, required 6", b_miss);
                end
            end
        end
        n_cmp++;
        if (b_miss !== 3'd7 || b_addr !== 32'h4) begin
            n_err++; $display("FAIL sat_final: miss=%0d addr=%h, required 7/00000004", b_miss, b_addr);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_miss();
        test_stall();
        test_redirect();
        test_random();
        test_wrap_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
